// File: rtl/tile_fetch_agu.sv
// tile_fetch_agu: stride-programmable 2-D tile address generator for one BRAM read port.
// Define FETCH_LAST_EN to add the rd_last output marking the final element of a tile.
module tile_fetch_agu #(
  parameter int ADDR_WIDTH = 16,
  parameter int DIM_WIDTH  = 10,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  reset_tile_ptr,
  input  logic [ADDR_WIDTH-1:0] cfg_base,
  input  logic [ADDR_WIDTH-1:0] cfg_db_offset,
  input  logic                  cfg_db_sel,
  input  logic [DIM_WIDTH-1:0]  cfg_rows,
  input  logic [DIM_WIDTH-1:0]  cfg_cols,
  input  logic [ADDR_WIDTH-1:0] cfg_row_stride,
  input  logic [ADDR_WIDTH-1:0] cfg_col_stride,
  input  logic [ADDR_WIDTH-1:0] cfg_tile_stride,
  input  logic                  cfg_hold_tile,
  input  logic                  rd_ready,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic                  bram_en,
  output logic                  rd_valid,
  output logic                  busy,
  output logic                  fetch_done
`ifdef FETCH_LAST_EN
  ,
  output logic                  rd_last
`endif
);

  localparam logic [DIM_WIDTH-1:0]  DIM_ONE    = DIM_WIDTH'(1);
  localparam logic [DIM_WIDTH-1:0]  DIM_ZERO   = {DIM_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO  = {ADDR_WIDTH{1'b0}};
  localparam logic [2:0]            DRAIN_LAST = 3'(RD_LATENCY);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [DIM_WIDTH-1:0]    c_q, c_d, r_q, r_d;
  logic [DIM_WIDTH-1:0]    rows_q, rows_d, cols_q, cols_d;
  logic [ADDR_WIDTH-1:0]   row_stride_q, row_stride_d;
  logic [ADDR_WIDTH-1:0]   col_stride_q, col_stride_d;
  logic [ADDR_WIDTH-1:0]   tile_stride_q, tile_stride_d;
  logic                    hold_tile_q, hold_tile_d;
  logic [ADDR_WIDTH-1:0]   row_acc_q, row_acc_d;
  logic [ADDR_WIDTH-1:0]   cur_q, cur_d;
  logic [ADDR_WIDTH-1:0]   tile_off_q, tile_off_d;
  logic [2:0]              drain_q, drain_d;
  logic [ADDR_WIDTH-1:0]   bram_addr_q, bram_addr_d;
  logic                    bram_en_q, bram_en_d;
  logic                    busy_q, busy_d;
  logic                    fetch_done_q, fetch_done_d;
  logic [RD_LATENCY-1:0]   vpipe_q, vpipe_d;
  logic [ADDR_WIDTH-1:0]   start_addr_s;
  logic                    zero_size_s, col_end_s, last_elem_s, issue_s, tile_adv_s;

  // The first address of a tile folds base, buffer half and tile offset together once.
  assign start_addr_s = cfg_base + (cfg_db_sel ? cfg_db_offset : ADDR_ZERO) + tile_off_q;
  assign zero_size_s  = (cfg_rows == DIM_ZERO) || (cfg_cols == DIM_ZERO);
  assign col_end_s    = (c_q == cols_q - DIM_ONE);
  assign last_elem_s  = col_end_s && (r_q == rows_q - DIM_ONE);

  assign bram_addr  = bram_addr_q;
  assign bram_en    = bram_en_q;
  assign rd_valid   = vpipe_q[RD_LATENCY-1];
  assign busy       = busy_q;
  assign fetch_done = fetch_done_q;

  // Next-state, loop counters, address accumulators and output next values.
  always_comb begin
    state_d       = state_q;
    c_d           = c_q;
    r_d           = r_q;
    rows_d        = rows_q;
    cols_d        = cols_q;
    row_stride_d  = row_stride_q;
    col_stride_d  = col_stride_q;
    tile_stride_d = tile_stride_q;
    hold_tile_d   = hold_tile_q;
    row_acc_d     = row_acc_q;
    cur_d         = cur_q;
    drain_d       = drain_q;
    bram_addr_d   = bram_addr_q;
    issue_s       = 1'b0;
    tile_adv_s    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          rows_d        = cfg_rows;
          cols_d        = cfg_cols;
          row_stride_d  = cfg_row_stride;
          col_stride_d  = cfg_col_stride;
          tile_stride_d = cfg_tile_stride;
          hold_tile_d   = cfg_hold_tile;
          row_acc_d     = start_addr_s;
          cur_d         = start_addr_s;
          c_d           = DIM_ZERO;
          r_d           = DIM_ZERO;
          state_d       = zero_size_s ? S_DONE : S_FETCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (rd_ready) begin
          issue_s     = 1'b1;
          bram_addr_d = cur_q;
          if (col_end_s) begin
            // Row wrap: restart the column walk from the next row's base.
            c_d       = DIM_ZERO;
            row_acc_d = row_acc_q + row_stride_q;
            cur_d     = row_acc_q + row_stride_q;
            if (last_elem_s) begin
              state_d = S_DRAIN;
              drain_d = 3'd0;
            end else begin
              r_d = r_q + DIM_ONE;
            end
          end else begin
            c_d   = c_q + DIM_ONE;
            cur_d = cur_q + col_stride_q;
          end
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DRAIN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (drain_q == DRAIN_LAST) begin
          state_d = S_DONE;
        end else begin
          drain_d = drain_q + 3'd1;
        end
      end
      S_DONE: begin
        state_d    = S_IDLE;
        tile_adv_s = !abort && !hold_tile_q;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (reset_tile_ptr) begin
      tile_off_d = ADDR_ZERO;
    end else if (tile_adv_s) begin
      tile_off_d = tile_off_q + tile_stride_q;
    end else begin
      tile_off_d = tile_off_q;
    end

    bram_en_d    = issue_s;
    busy_d       = (state_d == S_FETCH) || (state_d == S_DRAIN);
    fetch_done_d = (state_d == S_DONE);

    vpipe_d[0] = bram_en_q && !abort;
    for (int i = 1; i < RD_LATENCY; i++) begin
      vpipe_d[i] = vpipe_q[i-1] && !abort;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      c_q           <= DIM_ZERO;
      r_q           <= DIM_ZERO;
      rows_q        <= DIM_ZERO;
      cols_q        <= DIM_ZERO;
      row_stride_q  <= ADDR_ZERO;
      col_stride_q  <= ADDR_ZERO;
      tile_stride_q <= ADDR_ZERO;
      hold_tile_q   <= 1'b0;
      row_acc_q     <= ADDR_ZERO;
      cur_q         <= ADDR_ZERO;
      tile_off_q    <= ADDR_ZERO;
      drain_q       <= 3'd0;
      bram_addr_q   <= ADDR_ZERO;
      bram_en_q     <= 1'b0;
      busy_q        <= 1'b0;
      fetch_done_q  <= 1'b0;
      vpipe_q       <= {RD_LATENCY{1'b0}};
    end else begin
      state_q       <= state_d;
      c_q           <= c_d;
      r_q           <= r_d;
      rows_q        <= rows_d;
      cols_q        <= cols_d;
      row_stride_q  <= row_stride_d;
      col_stride_q  <= col_stride_d;
      tile_stride_q <= tile_stride_d;
      hold_tile_q   <= hold_tile_d;
      row_acc_q     <= row_acc_d;
      cur_q         <= cur_d;
      tile_off_q    <= tile_off_d;
      drain_q       <= drain_d;
      bram_addr_q   <= bram_addr_d;
      bram_en_q     <= bram_en_d;
      busy_q        <= busy_d;
      fetch_done_q  <= fetch_done_d;
      vpipe_q       <= vpipe_d;
    end
  end

`ifdef FETCH_LAST_EN
  logic                  last_q, last_d;
  logic [RD_LATENCY-1:0] lpipe_q, lpipe_d;

  // Last-element flag rides alongside bram_en through the same valid pipeline.
  always_comb begin
    last_d     = issue_s && last_elem_s;
    lpipe_d[0] = last_q && !abort;
    for (int i = 1; i < RD_LATENCY; i++) begin
      lpipe_d[i] = lpipe_q[i-1] && !abort;
    end
  end

  // Last-element pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q  <= 1'b0;
      lpipe_q <= {RD_LATENCY{1'b0}};
    end else begin
      last_q  <= last_d;
      lpipe_q <= lpipe_d;
    end
  end

  assign rd_last = lpipe_q[RD_LATENCY-1];
`endif

endmodule
